// File: rtl/oddr_patgen_pkg.sv
// rtl/oddr_patgen_pkg.sv - shared types and constants for the ODDR pattern generator
package oddr_patgen_pkg;

  // Pattern selection, sampled when a run is started
  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_CLKFWD = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_PRBS7  = 2'd3
  } mode_e;

  // Run control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // PRBS7 x^7+x^6+1: state bit 0 is the newest bit, bit 6 the oldest
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  // Next stream bit for a given LFSR state (b[n] = b[n-7] ^ b[n-6])
  function automatic logic prbs7_fb(input logic [6:0] s);
    return s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
  endfunction

endpackage

// File: rtl/oddr_patgen_prbs7.sv
// rtl/oddr_patgen_prbs7.sv - PRBS7 LFSR producing two stream bits per beat
module oddr_patgen_prbs7
  import oddr_patgen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  output logic [1:0] bits
);

  logic [6:0] lfsr_q;
  logic [6:0] step1;

  // bits[0] is the first step's bit (D1), bits[1] the second (D2)
  always_comb begin
    bits[0] = prbs7_fb(lfsr_q);
    step1   = {lfsr_q[5:0], bits[0]};
    bits[1] = prbs7_fb(step1);
  end

  // Reload seed on run start, advance two steps per emitted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS7_SEED;
    end else if (load) begin
      lfsr_q <= PRBS7_SEED;
    end else if (en) begin
      lfsr_q <= {step1[5:0], bits[1]};
    end
  end

endmodule

// File: rtl/oddr_pattern_gen.sv
// rtl/oddr_pattern_gen.sv - multi-lane DDR pattern generator; ODDR_PATGEN_PRBS_EN enables PRBS7
module oddr_pattern_gen
  import oddr_patgen_pkg::*;
#(
  parameter int   LANES      = 4,
  parameter int   BURST_W    = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [1:0]         const_bits,
  input  logic [LANES-1:0]   invert,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] beat_cnt,
  output logic [LANES-1:0]   ddr_out
);

  localparam int CNT_W = 2 * LANES;

  state_e             state;
  mode_e              mode_q;
  logic [1:0]         cb_q;
  logic [LANES-1:0]   inv_q;
  logic [BURST_W-1:0] len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LANES-1:0]   d1_q, d2_q;
  logic [LANES-1:0]   beat_d1, beat_d2;
  logic [BURST_W:0]   beat_next;
  logic               last_beat;
  logic               accept;
  logic               prbs_en;
  logic [1:0]         prbs_bits;

  assign accept    = (state == ST_IDLE) && start && !stop;
  assign prbs_en   = (state == ST_RUN) && !stop;
  assign beat_next = {1'b0, beat_cnt} + {{BURST_W{1'b0}}, 1'b1};
  assign last_beat = (len_q != '0) && (beat_next == {1'b0, len_q});

`ifdef ODDR_PATGEN_PRBS_EN
  oddr_patgen_prbs7 u_prbs7 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (prbs_en),
    .bits  (prbs_bits)
  );
`else
  // Without the LFSR, PRBS7 mode degenerates to a constant-low pattern
  assign prbs_bits = 2'b00;
`endif

  // Per-lane D1/D2 for the beat emitted this cycle, inversion applied
  always_comb begin
    beat_d1 = '0;
    beat_d2 = '0;
    for (int l = 0; l < LANES; l++) begin
      case (mode_q)
        MODE_CONST:  begin beat_d1[l] = cb_q[0];        beat_d2[l] = cb_q[1];          end
        MODE_CLKFWD: begin beat_d1[l] = 1'b1;           beat_d2[l] = 1'b0;             end
        MODE_COUNT:  begin beat_d1[l] = cnt_q[2*l];     beat_d2[l] = cnt_q[2*l+1];     end
        MODE_PRBS7:  begin beat_d1[l] = prbs_bits[0];   beat_d2[l] = prbs_bits[1];     end
        default:     begin beat_d1[l] = 1'b0;           beat_d2[l] = 1'b0;             end
      endcase
    end
    beat_d1 = beat_d1 ^ inv_q;
    beat_d2 = beat_d2 ^ inv_q;
  end

  // Run FSM with registered status, beat counter and ODDR data inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      beat_cnt <= '0;
      mode_q   <= MODE_CONST;
      cb_q     <= 2'b00;
      inv_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      d1_q     <= {LANES{IDLE_LEVEL}};
      d2_q     <= {LANES{IDLE_LEVEL}};
    end else begin
      done <= 1'b0;
      d1_q <= {LANES{IDLE_LEVEL}};
      d2_q <= {LANES{IDLE_LEVEL}};
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            mode_q   <= mode_e'(mode);
            cb_q     <= const_bits;
            inv_q    <= invert;
            len_q    <= burst_len;
            beat_cnt <= '0;
            cnt_q    <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            d1_q  <= beat_d1;
            d2_q  <= beat_d2;
            cnt_q <= cnt_q + 1'b1;
            if (beat_cnt != '1) begin
              beat_cnt <= beat_next[BURST_W-1:0];
            end
            if (last_beat) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ODDR per lane: SAME_EDGE capture, async reset from inverted rst_n, INIT 0
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic q1, q2;

    // Capture both data bits on the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q1 <= 1'b0;
        q2 <= 1'b0;
      end else begin
        q1 <= d1_q[l];
        q2 <= d2_q[l];
      end
    end

    assign ddr_out[l] = clk ? q1 : q2;
  end

endmodule

// File: tb/tb_oddr_pattern_gen.sv
// tb/tb_oddr_pattern_gen.sv - directed table-driven bench for oddr_pattern_gen
module tb_oddr_pattern_gen;

  localparam int L  = 4;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    const_bits = 2'd0;
  logic [L-1:0]  invert = '0;
  logic [BW-1:0] burst_len = '0;
  logic          busy, done;
  logic [BW-1:0] beat_cnt;
  logic [L-1:0]  ddr_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit prbs_ref [0:511];

  typedef struct {
    logic [1:0]   mode;
    logic [1:0]   cb;
    logic [L-1:0] inv;
    int           len;
    int           stop_at;
    bit           poke;
    int           exp_beats;
    bit           exp_done;
  } vec_t;

  vec_t vecs [0:7];
  vec_t r10;

  oddr_pattern_gen #(.LANES(L), .BURST_W(BW), .IDLE_LEVEL(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .const_bits (const_bits),
    .invert     (invert),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .beat_cnt   (beat_cnt),
    .ddr_out    (ddr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {D2 lanes, D1 lanes} for beat k (1-based) of a run
  function automatic logic [2*L-1:0] exp_beat(input vec_t v, input int k);
    logic [2*L-1:0] cnt;
    logic [L-1:0]   d1, d2;
    cnt = (2*L)'(k - 1);
    for (int l = 0; l < L; l++) begin
      case (v.mode)
        2'd0: begin d1[l] = v.cb[0]; d2[l] = v.cb[1]; end
        2'd1: begin d1[l] = 1'b1;    d2[l] = 1'b0;    end
        2'd2: begin d1[l] = cnt[2*l]; d2[l] = cnt[2*l+1]; end
        default: begin
`ifdef ODDR_PATGEN_PRBS_EN
          d1[l] = prbs_ref[2*(k-1)];
          d2[l] = prbs_ref[2*(k-1)+1];
`else
          d1[l] = 1'b0;
          d2[l] = 1'b0;
`endif
        end
      endcase
    end
    d1 = d1 ^ v.inv;
    d2 = d2 ^ v.inv;
    return {d2, d1};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [2*L-1:0] e;
    int eff;
    logic exp_busy;
    eff = (v.stop_at != 0) ? v.stop_at : v.len;
    @(negedge clk);
    mode = v.mode; const_bits = v.cb; invert = v.inv; burst_len = BW'(v.len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= eff + 2; c++) begin
      @(posedge clk); #1;
      exp_busy = (v.stop_at != 0) ? (c <= v.stop_at) : (c < v.len);
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(exp_busy));
      check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(v.exp_done && c == v.len));
      check($sformatf("%s beat_cnt c%0d", tag, c), 32'(beat_cnt), 32'((c < eff) ? c : eff));
      if (c >= 2 && c - 1 <= eff) e = exp_beat(v, c - 1);
      else e = '0;
      check($sformatf("%s d1 c%0d", tag, c), 32'(ddr_out), 32'(e[L-1:0]));
      @(negedge clk); #1;
      check($sformatf("%s d2 c%0d", tag, c), 32'(ddr_out), 32'(e[2*L-1:L]));
      if (v.poke && c == 2) begin
        start = 1'b1; mode = 2'd0; const_bits = 2'b11; invert = '1; burst_len = BW'(2);
      end
      if (v.poke && c == 3) start = 1'b0;
      if (v.stop_at != 0 && c == v.stop_at) stop = 1'b1;
      if (v.stop_at != 0 && c == v.stop_at + 1) stop = 1'b0;
    end
    check($sformatf("%s final beat_cnt", tag), 32'(beat_cnt), 32'(v.exp_beats));
  endtask

  initial begin
    bit hist [0:518];
    for (int i = 0; i < 7; i++) hist[i] = 1'b1;
    for (int n = 7; n < 519; n++) hist[n] = hist[n-7] ^ hist[n-6];
    for (int i = 0; i < 512; i++) prbs_ref[i] = hist[i+7];

    //           mode   cb     inv      len  stop poke beats done
    vecs[0] = '{2'd1, 2'b00, 4'b0000,   8,   0,  0,   8,  1};
    vecs[1] = '{2'd0, 2'b10, 4'b0101,   4,   0,  0,   4,  1};
    vecs[2] = '{2'd0, 2'b01, 4'b1111,   1,   0,  0,   1,  1};
    vecs[3] = '{2'd2, 2'b00, 4'b0000, 260,   0,  0, 260,  1};
    vecs[4] = '{2'd2, 2'b00, 4'b1010,   5,   0,  0,   5,  1};
    vecs[5] = '{2'd3, 2'b00, 4'b0000,   0, 200,  0, 200,  0};
    vecs[6] = '{2'd3, 2'b11, 4'b0011,   9,   0,  0,   9,  1};
    vecs[7] = '{2'd1, 2'b00, 4'b0000,   6,   0,  1,   6,  1};
    r10     = '{2'd1, 2'b00, 4'b0110,  10,   0,  0,  10,  1};

    // Reset state, both clock phases
    #2;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset beat_cnt", 32'(beat_cnt), 32'd0);
    @(posedge clk); #1;
    check("reset ddr_out high phase", 32'(ddr_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle ddr_out", 32'(ddr_out), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start and stop together in IDLE: no run, counters untouched
    @(negedge clk);
    mode = 2'd1; invert = '0; burst_len = BW'(4); start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("start_stop busy c%0d", c), 32'(busy), 32'd0);
      check($sformatf("start_stop beat_cnt c%0d", c), 32'(beat_cnt), 32'(vecs[7].exp_beats));
      check($sformatf("start_stop ddr_out c%0d", c), 32'(ddr_out), 32'd0);
    end

    // Reset in the middle of a 10-beat run, while beat 5 is on the pad
    @(negedge clk);
    mode = 2'd1; invert = '0; burst_len = BW'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("midrun pre-reset d1", 32'(ddr_out), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check("midrun reset ddr_out", 32'(ddr_out), 32'd0);
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset beat_cnt", 32'(beat_cnt), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("midrun done c%0d", c), 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(r10, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
